// File: rtl/avalon_mm_arb_master_if.sv
// Avalon-MM master bus bundle shared by the arbitrated master and its slave.
interface avalon_mm_arb_master_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic [AW-1:0] ADDRESS;
    logic          BEGINTRANSFER;
    logic          READ;
    logic          WRITE;
    logic [DW-1:0] WRITEDATA;
    logic          LOCK;
    logic [DW-1:0] READDATA;
    logic          WAITREQUEST;

    modport master (
        output ADDRESS, BEGINTRANSFER, READ, WRITE, WRITEDATA, LOCK,
        input  READDATA, WAITREQUEST
    );

    modport slave (
        input  ADDRESS, BEGINTRANSFER, READ, WRITE, WRITEDATA, LOCK,
        output READDATA, WAITREQUEST
    );
endinterface

// File: rtl/avalon_mm_arb_master.sv
// NCH request channels sharing one Avalon-MM master port through a round-robin
// arbiter, with locked bursts, WAITREQUEST timeout and per-channel done/err pulses.
module avalon_mm_arb_master #(
    parameter int unsigned NCH     = 2,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [NCH-1:0]      req_start,
    input  logic [NCH-1:0]      req_rnw,
    input  logic [NCH-1:0]      req_lock,
    input  logic [NCH*AW-1:0]   req_addr,
    input  logic [NCH*DW-1:0]   req_wdata,
    output logic [NCH-1:0]      req_done,
    output logic [NCH-1:0]      req_err,
    output logic [DW-1:0]       rdata,
    output logic [NCH-1:0]      grant,
    output logic                busy,
    avalon_mm_arb_master_if.master avm
);
    localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]     state_q,     state_d;
    logic [PW-1:0]  ptr_q,       ptr_d;
    logic           lock_hold_q, lock_hold_d;
    logic [NCH-1:0] grant_q,     grant_d;
    logic           rnw_q,       rnw_d;
    logic [AW-1:0]  addr_q,      addr_d;
    logic [DW-1:0]  wdata_q,     wdata_d;
    logic           bt_q,        bt_d;
    logic           read_q,      read_d;
    logic           write_q,     write_d;
    logic           lock_q,      lock_d;
    logic [CW-1:0]  cnt_q,       cnt_d;
    logic [NCH-1:0] done_q,      done_d;
    logic [NCH-1:0] errp_q,      errp_d;
    logic [DW-1:0]  rdata_q,     rdata_d;
    logic           busy_q,      busy_d;

    logic [PW-1:0]  win;
    logic [PW-1:0]  idx;
    logic           found;
    logic           timeout_hit;

    // ptr_q doubles as the owner index while a transfer is in flight
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        lock_hold_d = lock_hold_q;
        grant_d     = grant_q;
        rnw_d       = rnw_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        bt_d        = 1'b0;
        read_d      = read_q;
        write_d     = write_q;
        cnt_d       = cnt_q;
        done_d      = '0;
        errp_d      = '0;
        rdata_d     = rdata_q;
        win         = ptr_q;
        idx         = ptr_q;
        found       = 1'b0;
        timeout_hit = (TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) == TIMEOUT);

        // round-robin search starting just after the last owner
        for (int i = 1; i <= int'(NCH); i++) begin
            idx = PW'((32'(ptr_q) + 32'(i)) % NCH);
            if (!found && req_start[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        if (lock_hold_q && req_start[ptr_q]) begin
            win   = ptr_q;
            found = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (lock_hold_q && !req_start[ptr_q]) lock_hold_d = 1'b0;
                if (found) begin
                    state_d      = S_ACCESS;
                    ptr_d        = win;
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    rnw_d        = req_rnw[win];
                    addr_d       = req_addr[32'(win)*AW +: AW];
                    wdata_d      = req_wdata[32'(win)*DW +: DW];
                    bt_d         = 1'b1;
                    read_d       = req_rnw[win];
                    write_d      = !req_rnw[win];
                    cnt_d        = '0;
                end
            end
            S_ACCESS: begin
                if (!avm.WAITREQUEST) begin
                    state_d = S_RESP;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    done_d  = grant_q;
                    if (rnw_q) rdata_d = avm.READDATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (timeout_hit) begin
                        state_d = S_RESP;
                        read_d  = 1'b0;
                        write_d = 1'b0;
                        done_d  = grant_q;
                        errp_d  = grant_q;
                        rdata_d = '0;
                    end
                end
            end
            S_RESP: begin
                state_d     = S_IDLE;
                lock_hold_d = req_lock[ptr_q];
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        lock_d = busy_d && (lock_hold_d || req_lock[ptr_d]);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            ptr_q       <= PW'(NCH - 1);
            lock_hold_q <= 1'b0;
            grant_q     <= '0;
            rnw_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            bt_q        <= 1'b0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            lock_q      <= 1'b0;
            cnt_q       <= '0;
            done_q      <= '0;
            errp_q      <= '0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            lock_hold_q <= lock_hold_d;
            grant_q     <= grant_d;
            rnw_q       <= rnw_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            bt_q        <= bt_d;
            read_q      <= read_d;
            write_q     <= write_d;
            lock_q      <= lock_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            errp_q      <= errp_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign req_done          = done_q;
    assign req_err           = errp_q;
    assign rdata             = rdata_q;
    assign grant             = grant_q;
    assign busy              = busy_q;
    assign avm.ADDRESS       = addr_q;
    assign avm.BEGINTRANSFER = bt_q;
    assign avm.READ          = read_q;
    assign avm.WRITE         = write_q;
    assign avm.WRITEDATA     = wdata_q;
    assign avm.LOCK          = lock_q;
endmodule

// File: tb/tb_avalon_mm_arb_master.sv
// Scoreboard bench for avalon_mm_arb_master: 2 channels, TIMEOUT=4, scripted slave.
module tb_avalon_mm_arb_master;
    localparam int unsigned NCH = 2;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic [NCH-1:0]    req_start = '0;
    logic [NCH-1:0]    req_rnw = '0;
    logic [NCH-1:0]    req_lock = '0;
    logic [NCH*AW-1:0] req_addr = '0;
    logic [NCH*DW-1:0] req_wdata = '0;
    logic [NCH-1:0]    req_done;
    logic [NCH-1:0]    req_err;
    logic [DW-1:0]     rdata;
    logic [NCH-1:0]    grant;
    logic              busy;

    avalon_mm_arb_master_if #(.AW(AW), .DW(DW)) bus ();

    avalon_mm_arb_master #(.NCH(NCH), .AW(AW), .DW(DW), .TIMEOUT(4)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .req_start(req_start), .req_rnw(req_rnw), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_done(req_done), .req_err(req_err), .rdata(rdata),
        .grant(grant), .busy(busy), .avm(bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          ch;
        logic        rnw;
        logic [31:0] addr;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          target[NCH];
    int          done_cnt[NCH];
    int          stall_cfg = 0;
    logic [31:0] rd_key = '0;
    logic [31:0] seen_addr = '0;

    assign bus.READDATA = bus.ADDRESS ^ rd_key;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic push_exp(input int ch, input logic rnw, input logic [31:0] addr,
                            input logic [31:0] rd, input logic err);
        exp_t e;
        e.ch = ch; e.rnw = rnw; e.addr = addr; e.rd = rd; e.err = err;
        sb.push_back(e);
    endtask

    task automatic set_req(input int ch, input logic rnw, input logic [31:0] addr, input logic [31:0] wd);
        req_rnw[ch] = rnw;
        req_addr[ch*AW +: AW] = addr;
        req_wdata[ch*DW +: DW] = wd;
    endtask

    task automatic wait_bt(input string tag);
        bit hit = 1'b0;
        for (int k = 0; k < 60 && !hit; k++) begin
            @(negedge CLK);
            if (bus.BEGINTRANSFER) hit = 1'b1;
        end
        if (!hit) check_eq({tag, "_bt_timeout"}, 64'(0), 64'(1));
    endtask

    task automatic wait_idle(input string tag);
        bit hit = 1'b0;
        for (int k = 0; k < 300 && !hit; k++) begin
            @(negedge CLK);
            if (done_cnt[0] == target[0] && done_cnt[1] == target[1] && !busy) hit = 1'b1;
        end
        if (!hit) check_eq({tag, "_idle_timeout"}, 64'(0), 64'(1));
    endtask

    // Requesters hold req_start until they have seen enough done pulses
    initial begin
        forever begin
            @(posedge CLK);
            #2;
            for (int c = 0; c < int'(NCH); c++) req_start[c] = (done_cnt[c] < target[c]);
        end
    end

    // Slave: stall_cfg WAITREQUEST cycles per transfer, then accept
    initial begin
        int rem;
        rem = 0;
        bus.WAITREQUEST = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            if (RST_N && (bus.READ || bus.WRITE)) begin
                if (bus.BEGINTRANSFER) rem = stall_cfg;
                bus.WAITREQUEST = (rem > 0);
                if (rem > 0) rem--;
            end else begin
                bus.WAITREQUEST = 1'b0;
            end
        end
    end

    // Completion monitor: pops the scoreboard on every done pulse
    initial begin
        exp_t           e;
        logic [NCH-1:0] v;
        forever begin
            @(negedge CLK);
            if (bus.BEGINTRANSFER) seen_addr = bus.ADDRESS;
            if (req_done != '0) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_done", 64'(req_done), 64'(0));
                end else begin
                    e = sb.pop_front();
                    v = '0;
                    v[e.ch] = 1'b1;
                    check_eq("done_ch", 64'(req_done), 64'(v));
                    check_eq("grant_at_done", 64'(grant), 64'(v));
                    check_eq("err", 64'(req_err), e.err ? 64'(v) : 64'(0));
                    check_eq("addr", 64'(seen_addr), 64'(e.addr));
                    if (e.rnw) check_eq("rdata", 64'(rdata), 64'(e.rd));
                end
                for (int c = 0; c < int'(NCH); c++) if (req_done[c]) done_cnt[c]++;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got running want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [1:0] order [4];
        for (int c = 0; c < int'(NCH); c++) begin target[c] = 0; done_cnt[c] = 0; end
        repeat (3) @(negedge CLK);
        check_eq("rst_grant", 64'(grant), 64'(0));
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_rw", 64'({bus.READ, bus.WRITE, bus.LOCK, bus.BEGINTRANSFER}), 64'(0));
        check_eq("rst_rdata", 64'(rdata), 64'(0));
        check_eq("rst_done", 64'({req_done, req_err}), 64'(0));
        RST_N = 1'b1;
        @(negedge CLK);

        // T1: single read, zero wait
        rd_key = 32'h100 ^ 32'hCAFEF00D;
        set_req(0, 1'b1, 32'h100, 32'h0);
        push_exp(0, 1'b1, 32'h100, 32'hCAFEF00D, 1'b0);
        target[0]++;
        wait_bt("t1");
        check_eq("t1_read", 64'({bus.READ, bus.WRITE}), 64'(2'b10));
        check_eq("t1_addr", 64'(bus.ADDRESS), 64'(32'h100));
        @(negedge CLK);
        check_eq("t1_read_drop", 64'(bus.READ), 64'(0));
        check_eq("t1_done", 64'(req_done), 64'(2'b01));
        check_eq("t1_rdata", 64'(rdata), 64'(32'hCAFEF00D));
        wait_idle("t1");

        // T2: both channels, two reads each; ch0 owned last so ch1 goes first
        set_req(0, 1'b1, 32'h300, 32'h0);
        set_req(1, 1'b1, 32'h400, 32'h0);
        for (int k = 0; k < 4; k++) begin
            n = (k % 2 == 0) ? 1 : 0;
            push_exp(n, 1'b1, (n == 0) ? 32'h300 : 32'h400,
                     ((n == 0) ? 32'h300 : 32'h400) ^ rd_key, 1'b0);
        end
        target[0] += 2; target[1] += 2;
        order[0] = 2'b10; order[1] = 2'b01; order[2] = 2'b10; order[3] = 2'b01;
        for (int k = 0; k < 4; k++) begin
            wait_bt("t2");
            check_eq($sformatf("t2_grant%0d", k), 64'(grant), 64'(order[k]));
        end
        wait_idle("t2");

        // T3: ch1 write with three stall cycles
        stall_cfg = 3;
        set_req(1, 1'b0, 32'h200, 32'h12345678);
        push_exp(1, 1'b0, 32'h200, 32'h0, 1'b0);
        target[1]++;
        wait_bt("t3");
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge CLK);
            check_eq($sformatf("t3_rw%0d", k), 64'({bus.READ, bus.WRITE}), 64'(2'b01));
            check_eq($sformatf("t3_addr%0d", k), 64'(bus.ADDRESS), 64'(32'h200));
            check_eq($sformatf("t3_wd%0d", k), 64'(bus.WRITEDATA), 64'(32'h12345678));
            check_eq($sformatf("t3_bt%0d", k), 64'(bus.BEGINTRANSFER), (k == 0) ? 64'(1) : 64'(0));
        end
        @(negedge CLK);
        check_eq("t3_write_drop", 64'(bus.WRITE), 64'(0));
        check_eq("t3_done", 64'(req_done), 64'(2'b10));
        wait_idle("t3");

        // T4: slave stuck, abort after 4 stalled edges
        stall_cfg = 1000;
        set_req(0, 1'b1, 32'h500, 32'h0);
        push_exp(0, 1'b1, 32'h500, 32'h0, 1'b1);
        target[0]++;
        wait_bt("t4");
        n = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (!bus.READ) break;
            n++;
        end
        check_eq("t4_read_cycles", 64'(n), 64'(4));
        check_eq("t4_err", 64'({req_done, req_err}), 64'(4'b0101));
        check_eq("t4_rdata", 64'(rdata), 64'(0));
        wait_idle("t4");
        stall_cfg = 0;

        // T5: locked ch0 burst of three keeps ch1 waiting
        set_req(0, 1'b1, 32'h600, 32'h0);
        set_req(1, 1'b1, 32'h700, 32'h0);
        req_lock[0] = 1'b1;
        for (int k = 0; k < 3; k++) push_exp(0, 1'b1, 32'h600, 32'h600 ^ rd_key, 1'b0);
        push_exp(1, 1'b1, 32'h700, 32'h700 ^ rd_key, 1'b0);
        target[0] += 3;
        for (int k = 0; k < 4; k++) begin
            wait_bt("t5");
            if (k == 0) target[1]++;
            check_eq($sformatf("t5_grant%0d", k), 64'(grant), (k < 3) ? 64'(2'b01) : 64'(2'b10));
            check_eq($sformatf("t5_lock%0d", k), 64'(bus.LOCK), (k < 3) ? 64'(1) : 64'(0));
        end
        wait_idle("t5");
        req_lock[0] = 1'b0;

        // T6: reset in the middle of a stalled locked read
        stall_cfg = 1000;
        req_lock[0] = 1'b1;
        set_req(0, 1'b1, 32'h800, 32'h0);
        target[0]++;
        wait_bt("t6");
        check_eq("t6_pre_read", 64'({bus.READ, bus.LOCK}), 64'(2'b11));
        RST_N = 1'b0;
        #1;
        check_eq("t6_rst_bus", 64'({bus.READ, bus.WRITE, bus.LOCK}), 64'(0));
        check_eq("t6_rst_state", 64'({busy, grant, req_done}), 64'(0));
        for (int c = 0; c < int'(NCH); c++) target[c] = done_cnt[c];
        stall_cfg = 0;
        req_lock[0] = 1'b0;
        repeat (3) @(negedge CLK);
        check_eq("t6_no_done", 64'(req_done), 64'(0));
        RST_N = 1'b1;
        set_req(1, 1'b1, 32'h900, 32'h0);
        push_exp(0, 1'b1, 32'h800, 32'h800 ^ rd_key, 1'b0);
        push_exp(1, 1'b1, 32'h900, 32'h900 ^ rd_key, 1'b0);
        target[0]++; target[1]++;
        wait_bt("t6");
        check_eq("t6_first_grant", 64'(grant), 64'(2'b01));
        wait_idle("t6");

        repeat (3) @(negedge CLK);
        check_eq("sb_left", 64'(sb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
